// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: BTB entry layout,
// direction-counter constants and the saturating counter update.
package bp_pkg;

   localparam logic [1:0] CTR_WEAK_T   = 2'b10;
   localparam logic [1:0] CTR_STRONG_T = 2'b11;
   localparam logic [1:0] CTR_RESET    = 2'b01;

   // Tag and target are held zero-extended to 32 bits so one entry type
   // serves every PC_W; the unused upper bits are constant zero.
   typedef struct packed {
      logic        valid;
      logic [31:0] tag;
      logic [31:0] target;
      logic [1:0]  ctr;
   } btb_entry_t;

   localparam int unsigned ENTRY_W = $bits(btb_entry_t);

   function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
      if (taken) begin
         return (ctr == 2'b11) ? ctr : ctr + 2'd1;
      end
      return (ctr == 2'b00) ? ctr : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/btb_table.sv
// Flop-based BTB storage: two combinational read ports (fetch and EX),
// one synchronous write port, single-cycle clear of every entry on reset.
module btb_table
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [IDX_W-1:0]   i_rd0_idx,
   output logic [ENTRY_W-1:0] o_rd0_entry,
   input  logic [IDX_W-1:0]   i_rd1_idx,
   output logic [ENTRY_W-1:0] o_rd1_entry,
   input  logic               i_wr_en,
   input  logic [IDX_W-1:0]   i_wr_idx,
   input  logic [ENTRY_W-1:0] i_wr_entry
);

   btb_entry_t r_mem [ENTRIES];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
         end
      end else if (i_wr_en) begin
         r_mem[i_wr_idx] <= i_wr_entry;
      end
   end

   // Reads see the pre-write contents; no bypass from the write port.
   assign o_rd0_entry = r_mem[i_rd0_idx];
   assign o_rd1_entry = r_mem[i_rd1_idx];

endmodule

// File: rtl/branch_predict_unit.sv
// Branch unit: same-cycle BTB prediction for fetch, EX-stage resolution with
// redirect on mispredict, BTB training policy and saturating statistics.
module branch_predict_unit
   import bp_pkg::*;
#(
   parameter int unsigned PC_W    = 9,
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PC_W-1:0]  if_pc,
   output logic             pred_taken,
   output logic [31:0]      pred_target,
   input  logic             ex_valid,
   input  logic [PC_W-1:0]  ex_pc,
   input  logic [31:0]      ex_imm,
   input  logic             ex_branch,
   input  logic             ex_jal,
   input  logic             ex_jalr,
   input  logic [31:0]      ex_alu_result,
   input  logic             ex_pred_taken,
   input  logic [31:0]      ex_pred_target,
   output logic [31:0]      pc_imm,
   output logic [31:0]      pc_four,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);

   logic [IDX_W-1:0]   w_if_idx;
   logic [IDX_W-1:0]   w_ex_idx;
   logic [31:0]        w_if_tag;
   logic [31:0]        w_ex_tag;
   logic [ENTRY_W-1:0] w_if_raw;
   logic [ENTRY_W-1:0] w_ex_raw;
   btb_entry_t         w_if_entry;
   btb_entry_t         w_ex_entry;
   btb_entry_t         w_wr_entry;
   logic               w_wr_en;
   logic               w_if_hit;
   logic               w_ex_hit;
   logic               w_active;
   logic               w_taken;
   logic               w_mispredict;
   logic [31:0]        w_pc_ext;
   logic [31:0]        w_stored_tgt;
   logic [CNT_W-1:0]   r_branch_count;
   logic [CNT_W-1:0]   r_mispredict_count;
   logic               w_unused;

   assign w_if_idx = if_pc[IDX_W+1:2];
   assign w_ex_idx = ex_pc[IDX_W+1:2];
   assign w_if_tag = 32'(if_pc[PC_W-1:IDX_W+2]);
   assign w_ex_tag = 32'(ex_pc[PC_W-1:IDX_W+2]);
   assign w_unused = ^if_pc[1:0];

   btb_table #(
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W)
   ) u_btb (
      .clk         (clk),
      .reset       (reset),
      .i_rd0_idx   (w_if_idx),
      .o_rd0_entry (w_if_raw),
      .i_rd1_idx   (w_ex_idx),
      .o_rd1_entry (w_ex_raw),
      .i_wr_en     (w_wr_en),
      .i_wr_idx    (w_ex_idx),
      .i_wr_entry  (w_wr_entry)
   );

   assign w_if_entry = w_if_raw;
   assign w_ex_entry = w_ex_raw;

   assign w_if_hit    = w_if_entry.valid && (w_if_entry.tag == w_if_tag);
   assign pred_taken  = w_if_hit & w_if_entry.ctr[1];
   assign pred_target = pred_taken ? w_if_entry.target : '0;

   assign w_pc_ext    = 32'(ex_pc);
   assign pc_imm      = ex_jalr ? {ex_alu_result[31:1], 1'b0} : w_pc_ext + ex_imm;
   assign pc_four     = w_pc_ext + 32'd4;

   assign w_active     = ex_valid & (ex_branch | ex_jal | ex_jalr);
   assign w_taken      = ex_jal | ex_jalr | (ex_branch & ex_alu_result[0]);
   assign w_mispredict = (w_taken != ex_pred_taken) || (w_taken && (ex_pred_target != pc_imm));
   assign redirect     = w_active & w_mispredict;
   assign redirect_pc  = w_taken ? pc_imm : pc_four;

   // Targets beyond the PC range are truncated on store.
   assign w_stored_tgt = 32'(pc_imm[PC_W-1:0]);
   assign w_ex_hit     = w_ex_entry.valid && (w_ex_entry.tag == w_ex_tag);

   always_comb begin
      w_wr_en    = 1'b0;
      w_wr_entry = w_ex_entry;
      if (w_active) begin
         if (ex_jal | ex_jalr) begin
            w_wr_en           = 1'b1;
            w_wr_entry.valid  = 1'b1;
            w_wr_entry.tag    = w_ex_tag;
            w_wr_entry.target = w_stored_tgt;
            w_wr_entry.ctr    = CTR_STRONG_T;
         end else if (w_ex_hit) begin
            w_wr_en        = 1'b1;
            w_wr_entry.ctr = ctr_update(w_ex_entry.ctr, w_taken);
            if (w_taken) begin
               w_wr_entry.target = w_stored_tgt;
            end
         end else if (w_taken) begin
            w_wr_en           = 1'b1;
            w_wr_entry.valid  = 1'b1;
            w_wr_entry.tag    = w_ex_tag;
            w_wr_entry.target = w_stored_tgt;
            w_wr_entry.ctr    = CTR_WEAK_T;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_branch_count     <= '0;
         r_mispredict_count <= '0;
      end else begin
         if (w_active && (r_branch_count != '1)) begin
            r_branch_count <= r_branch_count + 1'b1;
         end
         if (redirect && (r_mispredict_count != '1)) begin
            r_mispredict_count <= r_mispredict_count + 1'b1;
         end
      end
   end

   assign branch_count     = r_branch_count;
   assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized and directed bench for branch_predict_unit: a driver pushes
// reference-model expectations into a scoreboard that a monitor drains.
module tb_branch_predict_unit;

   localparam int unsigned PC_W    = 9;
   localparam int unsigned ENTRIES = 16;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [PC_W-1:0]  if_pc;
   logic             pred_taken;
   logic [31:0]      pred_target;
   logic             ex_valid;
   logic [PC_W-1:0]  ex_pc;
   logic [31:0]      ex_imm;
   logic             ex_branch;
   logic             ex_jal;
   logic             ex_jalr;
   logic [31:0]      ex_alu_result;
   logic             ex_pred_taken;
   logic [31:0]      ex_pred_target;
   logic [31:0]      pc_imm;
   logic [31:0]      pc_four;
   logic             redirect;
   logic [31:0]      redirect_pc;
   logic [CNT_W-1:0] branch_count;
   logic [CNT_W-1:0] mispredict_count;

   always #5 clk = ~clk;

   branch_predict_unit #(
      .PC_W    (PC_W),
      .ENTRIES (ENTRIES),
      .CNT_W   (CNT_W)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .if_pc            (if_pc),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .ex_valid         (ex_valid),
      .ex_pc            (ex_pc),
      .ex_imm           (ex_imm),
      .ex_branch        (ex_branch),
      .ex_jal           (ex_jal),
      .ex_jalr          (ex_jalr),
      .ex_alu_result    (ex_alu_result),
      .ex_pred_taken    (ex_pred_taken),
      .ex_pred_target   (ex_pred_target),
      .pc_imm           (pc_imm),
      .pc_four          (pc_four),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   typedef struct {
      logic        pred_taken;
      logic [31:0] pred_target;
      logic        redirect;
      logic [31:0] redirect_pc;
      logic [31:0] pc_imm;
      logic [31:0] pc_four;
      logic [31:0] bc;
      logic [31:0] mc;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Reference model: table contents as plain arrays, counter as 0..3.
   bit          m_valid [ENTRIES];
   int unsigned m_tag   [ENTRIES];
   int unsigned m_target[ENTRIES];
   int          m_ctr   [ENTRIES];
   int unsigned m_bc;
   int unsigned m_mc;

   function automatic void m_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i]  = 1'b0;
         m_tag[i]    = 0;
         m_target[i] = 0;
         m_ctr[i]    = 1;
      end
      m_bc = 0;
      m_mc = 0;
   endfunction

   function automatic int unsigned idx_of(int unsigned pc);
      return (pc / 4) % ENTRIES;
   endfunction

   function automatic int unsigned tag_of(int unsigned pc);
      return pc / (4 * ENTRIES);
   endfunction

   function automatic bit m_hit(int unsigned pc);
      return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
   endfunction

   function automatic bit m_pred_taken(int unsigned pc);
      return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
   endfunction

   function automatic logic [31:0] m_pred_target(int unsigned pc);
      return m_pred_taken(pc) ? m_target[idx_of(pc)] : 0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pred_taken",       32'(pred_taken),       32'(e.pred_taken));
            chk("pred_target",      pred_target,           e.pred_target);
            chk("redirect",         32'(redirect),         32'(e.redirect));
            chk("redirect_pc",      redirect_pc,           e.redirect_pc);
            chk("pc_imm",           pc_imm,                e.pc_imm);
            chk("pc_four",          pc_four,               e.pc_four);
            chk("branch_count",     32'(branch_count),     e.bc);
            chk("mispredict_count", 32'(mispredict_count), e.mc);
         end
      end
   end

   task automatic step(input bit rst, input int unsigned ipc, input bit v, input int unsigned epc,
                       input logic [31:0] imm, input bit br, input bit jal, input bit jalr,
                       input logic [31:0] alu, input bit pt, input logic [31:0] ptgt);
      exp_t        e;
      bit          act, tk, misp;
      logic [31:0] tgt, four;
      int unsigned i;
      @(posedge clk);
      #1;
      reset          = rst;
      if_pc          = PC_W'(ipc);
      ex_valid       = v;
      ex_pc          = PC_W'(epc);
      ex_imm         = imm;
      ex_branch      = br;
      ex_jal         = jal;
      ex_jalr        = jalr;
      ex_alu_result  = alu;
      ex_pred_taken  = pt;
      ex_pred_target = ptgt;
      act  = v && (br || jal || jalr);
      tk   = jal || jalr || (br && alu[0]);
      tgt  = jalr ? (alu & ~32'd1) : (epc + imm);
      four = epc + 4;
      misp = (tk != pt) || (tk && (ptgt != tgt));
      e.pred_taken  = m_pred_taken(ipc);
      e.pred_target = m_pred_target(ipc);
      e.redirect    = act && misp;
      e.redirect_pc = tk ? tgt : four;
      e.pc_imm      = tgt;
      e.pc_four     = four;
      e.bc          = m_bc;
      e.mc          = m_mc;
      sb.push_back(e);
      // Advance the model to the state after the coming clock edge.
      if (rst) begin
         m_reset();
      end else if (act) begin
         if (m_bc < CNT_MAX) m_bc++;
         if (misp && m_mc < CNT_MAX) m_mc++;
         i = idx_of(epc);
         if (jal || jalr) begin
            m_valid[i] = 1'b1; m_tag[i] = tag_of(epc);
            m_target[i] = tgt % (1 << PC_W); m_ctr[i] = 3;
         end else if (m_hit(epc)) begin
            if (tk) begin
               m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
               m_target[i] = tgt % (1 << PC_W);
            end else begin
               m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
         end else if (tk) begin
            m_valid[i] = 1'b1; m_tag[i] = tag_of(epc);
            m_target[i] = tgt % (1 << PC_W); m_ctr[i] = 2;
         end
      end
   endtask

   task automatic idle(input int unsigned ipc);
      step(0, ipc, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic branch(input int unsigned ipc, input int unsigned epc, input logic [31:0] imm,
                         input bit cond, input bit pt, input logic [31:0] ptgt);
      step(0, ipc, 1, epc, imm, 1, 0, 0, {31'd0, cond}, pt, ptgt);
   endtask

   task automatic random_step(input bit allow_reset);
      int unsigned ipc, epc, ty;
      logic [31:0] imm, alu, ptgt;
      bit pt, rst;
      ipc = ($urandom_range(0, 1) == 1) ? 32'h010 + 32'h040 * $urandom_range(0, 3) : $urandom_range(0, 127) * 4;
      epc = ($urandom_range(0, 1) == 1) ? 32'h010 + 32'h040 * $urandom_range(0, 3) : $urandom_range(0, 127) * 4;
      imm = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, 255) * 4;
      alu = ($urandom_range(0, 3) == 0) ? $urandom() : {$urandom_range(0, 127), 1'b0, 1'($urandom_range(0, 1))};
      if ($urandom_range(0, 9) < 7) begin
         pt = m_pred_taken(epc); ptgt = m_pred_target(epc);
      end else begin
         pt = 1'($urandom_range(0, 1)); ptgt = $urandom_range(0, 511);
      end
      ty  = $urandom_range(0, 9);
      rst = allow_reset && ($urandom_range(0, 99) == 0);
      step(rst, ipc, ($urandom_range(0, 9) != 0), epc, imm,
           (ty < 6), (ty == 6 || ty == 7), (ty == 8), alu, pt, ptgt);
   endtask

   initial begin : driver
      m_reset();
      reset = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_imm = '0;
      ex_branch = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0; ex_alu_result = '0;
      ex_pred_taken = 1'b0; ex_pred_target = '0;
      repeat (2) @(posedge clk);

      idle(32'h010);                                  // reset state
      branch(32'h010, 32'h010, 32'h20, 1, 0, 0);      // cold taken branch
      idle(32'h010);                                  // now predicted taken -> 0x30
      branch(32'h010, 32'h010, 32'h20, 0, 1, 32'h30); // ctr 10 -> 01, redirect to 0x14
      idle(32'h010);
      for (int k = 0; k < 3; k++) branch(32'h010, 32'h010, 32'h20, 1, m_pred_taken(32'h010), m_pred_target(32'h010));
      branch(32'h010, 32'h010, 32'h20, 0, 1, 32'h30); // 11 -> 10, still taken
      idle(32'h010);
      step(0, 32'h020, 1, 32'h020, 0, 0, 0, 1, 32'h105, 0, 0); // JALR
      idle(32'h020);
      idle(32'h050);                                  // alias of 0x010, tag 1: miss
      branch(32'h050, 32'h050, 32'h40, 1, 0, 0);      // same-cycle update shows old result
      idle(32'h050);
      idle(32'h010);                                  // replaced by 0x050
      step(0, 32'h050, 0, 32'h050, 32'h8, 1, 0, 0, 1, 0, 0); // ex_valid=0 blocks all
      idle(32'h050);
      step(0, 32'h0A0, 1, 32'h0A0, 32'h200, 0, 1, 0, 0, 0, 0); // JAL, target 0x2A0 truncated
      step(0, 32'h0A0, 1, 32'h0A0, 32'h200, 0, 1, 0, 0, 1, 32'h0A0);

      for (int k = 0; k < 1500; k++) random_step(1);

      step(1, 32'h050, 1, 32'h050, 32'h40, 1, 0, 0, 1, 0, 0); // reset beats update
      idle(32'h050);
      idle(32'h020);

      for (int k = 0; k < 65540; k++) branch(32'h010 + 4 * (k % 4), 32'h100, 32'h10, 0, 1, 32'h110);
      idle(32'h010);
      step(1, 32'h010, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(32'h010);
      for (int k = 0; k < 300; k++) random_step(0);

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch unit with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It gives the fetch stage a same-cycle taken/target prediction for the current PC. It resolves branches, JAL and JALR in EX against the prediction that travelled with the instruction, and raises a redirect on a mispredict. It also keeps saturating statistics counters for branch and mispredict counts.

## Interface
Parameters:
- PC_W, 9, PC width in bits; must satisfy PC_W >= IDX_W+3
- ENTRIES, 16, BTB depth; power of two, >= 2; IDX_W = log2(ENTRIES)
- CNT_W, 16, width of each statistics counter

Ports:
- clk  in  1  clock; one clock domain only
- reset  in  1  synchronous, active-high reset
- if_pc  in  PC_W  fetch PC to predict
- pred_taken  out  1  prediction for if_pc: taken
- pred_target  out  32  predicted target, zero-extended; 0 when pred_taken=0
- ex_valid  in  1  the EX-stage instruction is valid
- ex_pc  in  PC_W  PC of the EX-stage instruction
- ex_imm  in  32  immediate
- ex_branch  in  1  conditional branch
- ex_jal  in  1  JAL
- ex_jalr  in  1  JALR
- ex_alu_result  in  32  for a branch, bit0 is the condition; for JALR, rs1+imm
- ex_pred_taken  in  1  prediction carried down the pipeline
- ex_pred_target  in  32  predicted target carried down the pipeline
- pc_imm  out  32  ex_jalr ? (ex_alu_result & ~1) : ex_pc+ex_imm
- pc_four  out  32  ex_pc+4
- redirect  out  1  mispredict: fetch must load redirect_pc and the younger stages must be flushed
- redirect_pc  out  32  correct next PC
- branch_count  out  CNT_W  resolved control-flow instructions
- mispredict_count  out  CNT_W  mispredicts

## Operation
- All PC arithmetic is 32-bit on {zero-extend(ex_pc)}.
- Index = pc[IDX_W+1:2]. Tag = pc[PC_W-1:IDX_W+2].
- Each entry holds:
  - valid
  - tag
  - target[PC_W-1:0]
  - ctr[1:0]
- Lookup, combinational: on a hit (valid and tag match), pred_taken = ctr[1] and pred_target = {0, target}. On a miss, both outputs are 0.
- Resolution is active when ex_valid and (ex_branch|ex_jal|ex_jalr). At most one of the three type inputs is high at a time.
- taken = ex_jal | ex_jalr | (ex_branch & ex_alu_result[0]).
- mispredict = taken != ex_pred_taken, or (taken & ex_pred_target != pc_imm).
- redirect = active & mispredict.
- redirect_pc = taken ? pc_imm : pc_four.
- A target at or above 2^PC_W is stored truncated. Such a branch therefore always mispredicts when taken; this is accepted behaviour.
- Update, on the clock edge when active:
  - Hit with taken: ctr increments, saturating at 11; target is rewritten.
  - Hit with not-taken: ctr decrements, saturating at 00.
  - JAL/JALR: ctr is set to 11.
  - Miss with taken: allocate the entry (valid=1, tag, target), with ctr=10 for a branch and 11 for JAL/JALR. Any previous occupant is replaced.
  - Miss with not-taken: no change.
- Statistics:
  - branch_count increments on every active cycle.
  - mispredict_count increments on every redirect.
  - Both saturate at all-ones and never wrap.

## Timing
- Lookup and all EX outputs are combinational. They have zero latency and no handshake.
- A table update becomes visible at if_pc from the cycle after the edge that wrote it.
- If the lookup and the update hit the same index in the same cycle, the lookup returns the pre-update contents. There is no bypass.
- Reset state:
  - All valid = 0.
  - All ctr = 01.
  - branch_count = 0 and mispredict_count = 0.
  - pred_taken = 0 and pred_target = 0 while the table is empty.
- Reset overrides any update presented in the same cycle.
- Reset asserted mid-sequence discards all training in one cycle.
- ex_valid=0 blocks updates and statistics and forces redirect=0. pc_imm and pc_four are still driven.

## Structure
- Shared package bp_pkg holds:
  - a typedef for the BTB entry struct;
  - constants CTR_WEAK_T=2'b10, CTR_STRONG_T=2'b11, CTR_RESET=2'b01;
  - a function for the saturating 2-bit counter update.
- Sub-module btb_table holds the entry array, the combinational read port and the synchronous write/reset port. The top level holds resolution, update policy and statistics.
- The table is built from flops, not inferred RAM, because reset clears every entry in a single cycle.

## Test plan
Defaults: PC_W=9, ENTRIES=16.

- **Reset:** assert reset 2 cycles, then if_pc=0x010 -> pred_taken=0, pred_target=0, both statistics counters = 0.
- **Cold taken branch:** ex_branch, ex_pc=0x010, ex_imm=0x20, alu bit0=1, ex_pred_taken=0 -> redirect=1, redirect_pc=0x30, mispredict_count=1. Next cycle, if_pc=0x010 -> pred_taken=1, pred_target=0x30.
- **Hysteresis:** starting from ctr=10, one not-taken branch at 0x010 (with ex_pred_taken=1) -> redirect=1, redirect_pc=0x014, and the next lookup gives pred_taken=0. Then 3 taken branches -> ctr saturates at 11, and 1 not-taken leaves pred_taken=1.
- **JALR:** ex_jalr, ex_alu_result=0x105, ex_pred_taken=0 -> pc_imm=0x104, redirect_pc=0x104, and the entry is allocated with ctr=11.
- **Alias and same-cycle write:**
  - Train 0x010, then look up 0x050 (same index, tag 1) -> miss, pred_taken=0.
  - Taken update at 0x050 in the same cycle as a lookup of 0x050 -> that cycle shows the old result.
- **Saturation and mid-run reset:** force both statistics counters to 0xFFFF via 65535 mispredicts -> they hold at 0xFFFF. Reset asserted mid-run -> the table and counters clear.
